// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM encoding, bus ACK/NACK levels and master command codes.
package i2c_pkg;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_ADDR      = 4'd1;
   localparam logic [3:0] S_ADDR_ACK  = 4'd2;
   localparam logic [3:0] S_PTR       = 4'd3;
   localparam logic [3:0] S_PTR_ACK   = 4'd4;
   localparam logic [3:0] S_WDATA     = 4'd5;
   localparam logic [3:0] S_WDATA_ACK = 4'd6;
   localparam logic [3:0] S_RDATA     = 4'd7;
   localparam logic [3:0] S_RDATA_ACK = 4'd8;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   typedef enum logic [2:0] {
      MCMD_NONE,
      MCMD_START,
      MCMD_WRITE,
      MCMD_READ,
      MCMD_STOP
   } i2c_mcmd_e;

   // Open-drain: showing a 0 on the bus means pulling SDA.
   function automatic logic sda_pull(input logic level);
      return (level == 1'b0);
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA into clk and emits single-cycle edge, START and STOP pulses.
module i2c_bus_sync (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_det_o,
   output logic stop_det_o
);

   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_hist_q;
   logic       sda_hist_q;
   logic [1:0] arm_q;
   logic       armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
         arm_q      <= 2'd0;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_hist_q <= scl_sync_q[1];
         sda_hist_q <= sda_sync_q[1];
         if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
      end
   end

   // Edges stay masked until the history holds a real bus sample, so leaving reset never fakes a START.
   assign armed       = (arm_q == 2'd3);
   assign sda_o       = sda_sync_q[1];
   assign scl_rise_o  = armed &  scl_sync_q[1] & ~scl_hist_q;
   assign scl_fall_o  = armed & ~scl_sync_q[1] &  scl_hist_q;
   assign start_det_o = armed & scl_sync_q[1] & scl_hist_q &  sda_hist_q & ~sda_sync_q[1];
   assign stop_det_o  = armed & scl_sync_q[1] & scl_hist_q & ~sda_hist_q &  sda_sync_q[1];

endmodule

// File: rtl/i2c_slave.sv
// I2C register-access slave: address match, pointer write, data write with auto-increment, sequential read.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h55
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_t,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
   logic [3:0] state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] sh_q, sh_d;
   logic       rw_q, rw_d;
   logic [1:0] ld_q, ld_d;
   logic       sda_t_q, sda_t_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       wr_q, wr_d;
   logic       rd_q, rd_d;
   logic       busy_q, busy_d;
   logic [7:0] byte_in;
   logic       last_bit;

   i2c_bus_sync u_sync (
      .clk         (clk),
      .rst         (rst),
      .scl_i       (scl_i),
      .sda_i       (sda_i),
      .sda_o       (sda_s),
      .scl_rise_o  (scl_rise),
      .scl_fall_o  (scl_fall),
      .start_det_o (start_det),
      .stop_det_o  (stop_det)
   );

   assign byte_in  = {sh_q[6:0], sda_s};
   assign last_bit = (cnt_q == 3'd7);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      rw_d    = rw_q;
      ld_d    = ld_q;
      sda_t_d = sda_t_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      busy_d  = busy_q;
      // The pointer advances the cycle after the write strobe has been seen with the old address.
      if (wr_q) addr_d = addr_q + 8'd1;
      if (start_det) begin
         state_d = S_ADDR;
         cnt_d   = 3'd0;
         ld_d    = 2'd0;
         sda_t_d = sda_pull(I2C_NACK);
         busy_d  = 1'b1;
      end else if (stop_det) begin
         state_d = S_IDLE;
         cnt_d   = 3'd0;
         ld_d    = 2'd0;
         sda_t_d = sda_pull(I2C_NACK);
         busy_d  = 1'b0;
      end else begin
         if (scl_rise && (state_q inside {S_ADDR, S_PTR, S_WDATA, S_RDATA})) cnt_d = cnt_q + 3'd1;
         case (state_q)
            S_ADDR: if (scl_rise) begin
               sh_d = byte_in;
               if (last_bit) begin
                  if (byte_in[7:1] == SLAVE_ADDR) begin
                     state_d = S_ADDR_ACK;
                     rw_d    = byte_in[0];
                  end else begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                  end
               end
            end
            S_PTR: if (scl_rise) begin
               sh_d = byte_in;
               if (last_bit) begin
                  addr_d  = byte_in;
                  state_d = S_PTR_ACK;
               end
            end
            S_WDATA: if (scl_rise) begin
               sh_d = byte_in;
               if (last_bit) begin
                  wdata_d = byte_in;
                  wr_d    = 1'b1;
                  state_d = S_WDATA_ACK;
               end
            end
            // ACK is driven from the fall after bit 8 to the fall after bit 9.
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!sda_t_q) begin
                     sda_t_d = sda_pull(I2C_ACK);
                  end else begin
                     sda_t_d = sda_pull(I2C_NACK);
                     state_d = S_PTR;
                  end
               end else if (scl_rise && rw_q) begin
                  state_d = S_RDATA;
                  ld_d    = 2'd1;
               end
            end
            S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
               if (!sda_t_q) begin
                  sda_t_d = sda_pull(I2C_ACK);
               end else begin
                  sda_t_d = sda_pull(I2C_NACK);
                  state_d = S_WDATA;
               end
            end
            // ld_q sequences strobe, wait, capture; it completes while SCL is still high after the ACK bit.
            S_RDATA: begin
               case (ld_q)
                  2'd1: begin
                     rd_d = 1'b1;
                     ld_d = 2'd2;
                  end
                  2'd2: ld_d = 2'd3;
                  2'd3: begin
                     sh_d = reg_rdata;
                     ld_d = 2'd0;
                  end
                  default: ;
               endcase
               if (scl_fall) begin
                  sda_t_d = sda_pull(sh_q[7]);
                  sh_d    = {sh_q[6:0], 1'b0};
               end
               if (scl_rise && last_bit) state_d = S_RDATA_ACK;
            end
            S_RDATA_ACK: begin
               if (scl_fall) begin
                  sda_t_d = sda_pull(I2C_NACK);
               end else if (scl_rise) begin
                  if (sda_s == I2C_NACK) begin
                     state_d = S_IDLE;
                  end else begin
                     addr_d  = addr_q + 8'd1;
                     state_d = S_RDATA;
                     ld_d    = 2'd1;
                  end
               end
            end
            S_IDLE:  ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         ld_q    <= 2'd0;
         sda_t_q <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ld_q    <= ld_d;
         sda_t_q <= sda_t_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
      end
      sh_q <= sh_d;
      rw_q <= rw_d;
   end

   assign sda_t     = sda_t_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign reg_wr    = wr_q;
   assign reg_rd    = rd_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, byte-level register model, directed and random transfers.
module tb_i2c_slave;

   localparam int         Q     = 50;
   localparam logic [6:0] SADDR = 7'h55;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_t, reg_wr, reg_rd, busy;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   wire        sda_line = sda_m & ~sda_t;

   int          checks = 0;
   int          errs   = 0;
   logic [7:0]  mem [0:255];
   logic [15:0] wr_log [$];
   logic [7:0]  rd_log [$];
   int          pull_cnt = 0;
   logic        overlap  = 1'b0;

   always #5 clk = ~clk;

   i2c_slave #(.SLAVE_ADDR(SADDR)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl_m),
      .sda_i     (sda_line),
      .sda_t     (sda_t),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rd    (reg_rd),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   // External register file and transaction logger.
   always @(posedge clk) begin
      if (reg_rd) begin
         reg_rdata <= mem[reg_addr];
         rd_log.push_back(reg_addr);
      end
      if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
      if (reg_wr && reg_rd) overlap <= 1'b1;
      if (sda_t) pull_cnt <= pull_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_start();
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b1; #Q;
      #Q;
   endtask

   task automatic write_bit(input logic b);
      sda_m = b; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      b = sda_line; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic b;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         d = {d[6:0], b};
      end
      write_bit(ack);
   endtask

   task automatic do_write(input logic [7:0] ptr, input logic [7:0] data[$]);
      logic        a;
      logic [7:0]  ea;
      logic [15:0] got;
      int          base;
      base = wr_log.size();
      bus_start();
      chk("wr_busy", busy, 1'b1);
      write_byte({SADDR, 1'b0}, a); chk("wr_addr_ack", a, 1'b0);
      write_byte(ptr, a);           chk("wr_ptr_ack", a, 1'b0);
      foreach (data[i]) begin
         write_byte(data[i], a);
         chk("wr_data_ack", a, 1'b0);
      end
      bus_stop();
      chk("wr_busy_after_stop", busy, 1'b0);
      chk("wr_count", wr_log.size() - base, data.size());
      foreach (data[i]) begin
         ea  = ptr + 8'(i);
         got = 'x;
         if (base + i < wr_log.size()) got = wr_log[base + i];
         chk("wr_entry", got, {ea, data[i]});
      end
   endtask

   task automatic do_read(input logic [7:0] ptr, input int n);
      logic       a;
      logic [7:0] d, ea, got;
      int         base;
      base = rd_log.size();
      bus_start();
      write_byte({SADDR, 1'b0}, a); chk("rd_waddr_ack", a, 1'b0);
      write_byte(ptr, a);           chk("rd_ptr_ack", a, 1'b0);
      bus_start();
      write_byte({SADDR, 1'b1}, a); chk("rd_raddr_ack", a, 1'b0);
      for (int i = 0; i < n; i++) begin
         ea = ptr + 8'(i);
         read_byte(d, (i == n - 1));
         chk("rd_byte", d, mem[ea]);
      end
      bus_stop();
      chk("rd_busy_after_stop", busy, 1'b0);
      chk("rd_count", rd_log.size() - base, n);
      for (int i = 0; i < n; i++) begin
         ea  = ptr + 8'(i);
         got = 'x;
         if (base + i < rd_log.size()) got = rd_log[base + i];
         chk("rd_entry", got, ea);
      end
   endtask

   initial begin
      logic       a, b;
      logic [7:0] q [$];
      int         wb, rb, pb;

      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

      repeat (4) @(posedge clk);
      #1;
      chk("rst_sda_t", sda_t, 1'b0);
      chk("rst_reg_addr", reg_addr, 8'h00);
      chk("rst_reg_wdata", reg_wdata, 8'h00);
      chk("rst_reg_wr", reg_wr, 1'b0);
      chk("rst_reg_rd", reg_rd, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("no_false_start", busy, 1'b0);
      #(Q - 1);

      q = '{8'hCD, 8'hCC};
      do_write(8'hBB, q);

      mem[8'h10] = 8'h5A;
      mem[8'h11] = 8'h3C;
      do_read(8'h10, 2);

      // Address mismatch: nobody answers, nothing is written.
      wb = wr_log.size();
      pb = pull_cnt;
      bus_start();
      write_byte(8'hA8, a); chk("mismatch_addr_nack", a, 1'b1);
      write_byte(8'h00, a); chk("mismatch_data_nack", a, 1'b1);
      bus_stop();
      chk("mismatch_sda_quiet", pull_cnt - pb, 0);
      chk("mismatch_no_write", wr_log.size() - wb, 0);
      chk("mismatch_busy", busy, 1'b0);

      q = '{8'h01, 8'h02};
      do_write(8'hFF, q);

      // STOP after four bits of a data byte.
      wb = wr_log.size();
      bus_start();
      write_byte({SADDR, 1'b0}, a); chk("abort_addr_ack", a, 1'b0);
      write_byte(8'h40, a);         chk("abort_ptr_ack", a, 1'b0);
      for (int i = 0; i < 4; i++) write_bit(1'b1);
      bus_stop();
      chk("abort_no_write", wr_log.size() - wb, 0);
      chk("abort_busy", busy, 1'b0);
      q = '{8'h77};
      do_write(8'h40, q);

      // Reset while the slave is driving a 0 data bit.
      mem[8'h20] = 8'h35;
      rb = rd_log.size();
      bus_start();
      write_byte({SADDR, 1'b0}, a);
      write_byte(8'h20, a);
      bus_start();
      write_byte({SADDR, 1'b1}, a); chk("rstrd_addr_ack", a, 1'b0);
      chk("rstrd_driving", sda_t, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rstrd_released", sda_t, 1'b0);
      chk("rstrd_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      pb = pull_cnt;
      for (int i = 0; i < 8; i++) read_bit(b);
      write_bit(1'b0);
      chk("rstrd_ignored", pull_cnt - pb, 0);
      chk("rstrd_busy_ignored", busy, 1'b0);
      bus_stop();
      chk("rstrd_rd_count", rd_log.size() - rb, 1);

      for (int t = 0; t < 4; t++) begin
         logic [7:0] p;
         int         n;
         p = 8'($urandom);
         n = $urandom_range(1, 3);
         q = {};
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         do_write(p, q);
         p = 8'($urandom);
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) mem[p + 8'(i)] = 8'($urandom);
         do_read(p, n);
      end

      chk("no_wr_rd_overlap", overlap, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h55, giving the 7-bit target address matched against the first byte after START.
REQ-002 SHALL have port clk  input  1  system clock; the single clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port scl_i  input  1  raw I2C SCL line, asynchronous to clk.
REQ-005 SHALL have port sda_i  input  1  raw I2C SDA line, asynchronous to clk.
REQ-006 SHALL have port sda_t  output  1  open-drain enable; 1 = pull SDA low, 0 = release.
REQ-007 SHALL have port reg_addr  output  8  register pointer presented to the external register file.
REQ-008 SHALL have port reg_wdata  output  8  write data for the external register file.
REQ-009 SHALL have port reg_wr  output  1  single-cycle write strobe.
REQ-010 SHALL have port reg_rd  output  1  single-cycle read strobe.
REQ-011 SHALL have port reg_rdata  input  8  read data, valid on the cycle after reg_rd.
REQ-012 SHALL have port busy  output  1  high from a valid START until STOP or an abort.

Function
REQ-013 SHALL pass scl_i and sda_i through 2-FF synchronizers, then one history register; all detection SHALL use the synchronized values only.
REQ-014 SHALL detect START (and repeated START) as SDA falling while SCL is high, from any state.
REQ-015 SHALL detect STOP as SDA rising while SCL is high, from any state; both STOP and START SHALL force the byte counter to 0.
REQ-016 SHALL sample SDA on the synchronized SCL rising edge, MSB first, and change sda_t only on the synchronized SCL falling edge.
REQ-017 SHALL use the FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-018 Transition: IDLE->ADDR on START.
REQ-019 Transition: ADDR->ADDR_ACK after 8 bits if the address matches; on a mismatch the FSM SHALL return to IDLE with sda_t held 0.
REQ-020 ADDR_ACK SHALL drive ACK (sda_t=1) for exactly one SCL period; then go to PTR if R/W=0, or RDATA if R/W=1.
REQ-021 PTR->PTR_ACK: after 8 bits, load reg_addr, ACK, then go to WDATA.
REQ-022 WDATA->WDATA_ACK: after 8 bits, pulse reg_wr for one clk with the current reg_addr/reg_wdata; ACK; increment reg_addr modulo 256 (0xFF wraps to 0x00).
REQ-023 On entry to RDATA, pulse reg_rd; capture reg_rdata on the next clk; shift it out MSB first (sda_t = ~bit).
REQ-024 RDATA_ACK SHALL release SDA and sample the master bit: ACK(0) -> increment reg_addr, go to RDATA; NACK(1) -> go to IDLE, SDA released until the next START.
REQ-025 A repeated START SHALL preserve reg_addr, so a pointer write followed by a read works.
REQ-026 reg_wr and reg_rd SHALL never be asserted in the same cycle.
REQ-027 Latency: reg_wr SHALL pulse within 4 clk of the 8th SCL rising edge of a data byte.
REQ-028 Clock ratio: clk SHALL be at least 16x the SCL frequency; no clock stretching is performed.

Reset
REQ-029 While rst=1 at a clk edge: state=IDLE, sda_t=0, reg_addr=0x00, reg_wdata=0x00, reg_wr=0, reg_rd=0, busy=0.
REQ-030 The synchronizers SHALL reset to 1 (idle bus), so reset itself SHALL NOT produce a false START.
REQ-031 Reset asserted mid-transfer SHALL release SDA on the next clk, and the block SHALL ignore the bus until a fresh START.

Structure
REQ-032 The state enum and the ACK/NACK constants SHALL live in a shared package, i2c_pkg, alongside the master's definitions.
REQ-033 START/STOP/edge detection SHALL be one sub-module, i2c_bus_sync, containing the synchronizers and emitting scl_rise, scl_fall, start_det and stop_det pulses.

Verification
REQ-034 Write: START, 0xAA, 0xBB, 0xCD, 0xCC, STOP -> ACK on all four bytes; reg_wr at reg_addr 0xBB data 0xCD, then reg_addr 0xBC data 0xCC.
REQ-035 Address mismatch: START, 0xA8, 0x00, STOP -> sda_t stays 0 throughout; no reg_wr; busy drops.
REQ-036 Read: START, 0xAA, 0x10, repeated START, 0xAB, master ACK, master NACK, STOP; reg_rdata=0x5A then 0x3C -> bytes 0x5A, 0x3C appear on SDA; reg_rd at addresses 0x10 and 0x11.
REQ-037 Wrap: pointer 0xFF, two data bytes 0x01, 0x02 -> writes to 0xFF and 0x00.
REQ-038 Abort: STOP after 4 bits of a data byte -> no reg_wr; FSM in IDLE; the next transaction completes normally.
REQ-039 Reset during RDATA with sda_t=1 -> sda_t=0 on the next clk; the bus is ignored until START.
